// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter/sequencer.
package alu_arb_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_FUNSEL_W = 4;
  localparam int DEF_FLAG_W   = 4;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side bus of the ALU arbiter; slave = arbiter, master = its environment.
interface alu_arbiter_if #(
  parameter int DATA_W   = alu_arb_pkg::DEF_DATA_W,
  parameter int FUNSEL_W = alu_arb_pkg::DEF_FUNSEL_W,
  parameter int FLAG_W   = alu_arb_pkg::DEF_FLAG_W
);

  logic                req0_valid;
  logic                req0_ready;
  logic [DATA_W-1:0]   req0_A;
  logic [DATA_W-1:0]   req0_B;
  logic [FUNSEL_W-1:0] req0_FunSel;

  logic                req1_valid;
  logic                req1_ready;
  logic [DATA_W-1:0]   req1_A;
  logic [DATA_W-1:0]   req1_B;
  logic [FUNSEL_W-1:0] req1_FunSel;

  logic                resp_valid;
  logic                resp_ready;
  logic                resp_id;
  logic [DATA_W-1:0]   resp_Out;
  logic [FLAG_W-1:0]   resp_Flags;

  logic [DATA_W-1:0]   alu_A;
  logic [DATA_W-1:0]   alu_B;
  logic [FUNSEL_W-1:0] alu_FunSel;
  logic [DATA_W-1:0]   alu_Out;
  logic [FLAG_W-1:0]   alu_Flags;

  logic                busy;

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_FunSel,
    output req0_ready,
    input  req1_valid, req1_A, req1_B, req1_FunSel,
    output req1_ready,
    output resp_valid, resp_id, resp_Out, resp_Flags,
    input  resp_ready,
    output alu_A, alu_B, alu_FunSel,
    input  alu_Out, alu_Flags,
    output busy
  );

  modport master (
    output req0_valid, req0_A, req0_B, req0_FunSel,
    input  req0_ready,
    output req1_valid, req1_A, req1_B, req1_FunSel,
    input  req1_ready,
    input  resp_valid, resp_id, resp_Out, resp_Flags,
    output resp_ready,
    input  alu_A, alu_B, alu_FunSel,
    output alu_Out, alu_Flags,
    input  busy
  );

endinterface

// File: rtl/alu_arb_rr.sv
// Two-way request picker. Round robin by default; ALU_ARB_FIXED_PRIO_EN selects fixed priority (port 0 first).
module alu_arb_rr
  import alu_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_id
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Pointer is still tracked by the caller but plays no part in fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant    = 2'b00;
    grant_id = PORT0;
    if (valid[0]) begin
      grant_id = PORT0;
    end else begin
      grant_id = PORT1;
    end
    if (enable && (valid != 2'b00)) begin
      grant = (grant_id == PORT1) ? 2'b10 : 2'b01;
    end
  end
`else
  always_comb begin
    grant    = 2'b00;
    grant_id = PORT0;
    if (valid == 2'b11) begin
      grant_id = ~last_grant;
    end else if (valid[1]) begin
      grant_id = PORT1;
    end else begin
      grant_id = PORT0;
    end
    if (enable && (valid != 2'b00)) begin
      grant = (grant_id == PORT1) ? 2'b10 : 2'b01;
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Grants one of two requesters, drives the shared ALU, waits out its registered flags and returns a tagged response.
// Arbitration policy is chosen in alu_arb_rr via ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FUNSEL_W = DEF_FUNSEL_W,
  parameter int FLAG_W   = DEF_FLAG_W
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  state_t              state, state_nxt;
  logic                last_grant;
  logic [1:0]          req_valid;
  logic [1:0]          grant;
  logic                grant_id;
  logic                req_hs;

  logic [DATA_W-1:0]   op_a_p0;
  logic [DATA_W-1:0]   op_b_p0;
  logic [FUNSEL_W-1:0] op_fs_p0;
  logic                op_id_p0;

  logic [DATA_W-1:0]   out_p1;
  logic [FLAG_W-1:0]   flags_p1;
  logic                id_p1;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  alu_arb_rr u_rr (
    .valid      (req_valid),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign req_hs         = |grant;
  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_hs) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= PORT1;
    end else begin
      state <= state_nxt;
      if (req_hs) begin
        last_grant <= grant_id;
      end
    end
  end

  // Stage p0: operands latched on the request handshake; they also feed the ALU directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_p0  <= '0;
      op_b_p0  <= '0;
      op_fs_p0 <= '0;
      op_id_p0 <= PORT0;
    end else if (req_hs) begin
      op_a_p0  <= (grant_id == PORT1) ? bus.req1_A      : bus.req0_A;
      op_b_p0  <= (grant_id == PORT1) ? bus.req1_B      : bus.req0_B;
      op_fs_p0 <= (grant_id == PORT1) ? bus.req1_FunSel : bus.req0_FunSel;
      op_id_p0 <= grant_id;
    end
  end

  // Stage p1: ALU result and its flags (updated at the end of ISSUE) captured at the end of CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1   <= '0;
      flags_p1 <= '0;
      id_p1    <= PORT0;
    end else if (state == CAPTURE) begin
      out_p1   <= bus.alu_Out;
      flags_p1 <= bus.alu_Flags;
      id_p1    <= op_id_p0;
    end
  end

  assign bus.alu_A      = op_a_p0;
  assign bus.alu_B      = op_b_p0;
  assign bus.alu_FunSel = op_fs_p0;

  assign bus.resp_valid = (state == RESP);
  assign bus.resp_id    = id_p1;
  assign bus.resp_Out   = out_p1;
  assign bus.resp_Flags = flags_p1;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural 8-bit ALU; define ALU_ARB_FIXED_PRIO_EN for the fixed-priority build.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  typedef struct packed {
    logic        id;
    logic [7:0]  out;
    logic [3:0]  flg;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  alu_arbiter_if bus ();

  alu_arbiter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic grant_q[$];
  int   grant_cnt = 0;
  int   resp_cnt  = 0;
  int   cyc       = 0;
  int   grant_cyc = 0;
  int   resp_cyc  = 0;
  logic [7:0]  last_out  = '0;
  logic [7:0]  last_out1 = '0;
  logic        last_id   = 1'b0;
  logic [3:0]  last_flg  = '0;
  logic        prev_hold  = 1'b0;
  logic        prev_valid = 1'b0;
  logic [12:0] prev_snap  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU: {carry, result}
  function automatic logic [8:0] alu_sum(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b);
    case (fs)
      4'b0100: alu_sum = {1'b0, a} + {1'b0, b};
      4'b0101: alu_sum = {1'b0, a} - {1'b0, b};
      4'b1000: alu_sum = {1'b0, a & b};
      4'b1001: alu_sum = {1'b0, a | b};
      4'b1010: alu_sum = {1'b0, a ^ b};
      default: alu_sum = {1'b0, a};
    endcase
  endfunction

  // Flags {Z, C, N, O}
  function automatic logic [3:0] alu_flg(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic       o;
    s = alu_sum(fs, a, b);
    o = (fs == 4'b0100) && (a[7] == b[7]) && (s[7] != a[7]);
    alu_flg = {(s[7:0] == 8'h00), s[8], s[7], o};
  endfunction

  function automatic exp_t exp_of(input logic id, input logic [3:0] fs, input logic [7:0] a,
                                  input logic [7:0] b, input int c);
    logic [8:0] s;
    s = alu_sum(fs, a, b);
    exp_of = '{id: id, out: s[7:0], flg: alu_flg(fs, a, b), cyc: c};
  endfunction

  logic [8:0] alu_s;
  assign alu_s       = alu_sum(bus.alu_FunSel, bus.alu_A, bus.alu_B);
  assign bus.alu_Out = alu_s[7:0];
  always @(posedge clk) bus.alu_Flags <= alu_flg(bus.alu_FunSel, bus.alu_A, bus.alu_B);

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      cyc++;
      if (bus.busy) check("rdy_while_busy", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back(exp_of(PORT0, bus.req0_FunSel, bus.req0_A, bus.req0_B, cyc));
        grant_q.push_back(PORT0);
        grant_cnt++;
        grant_cyc = cyc;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back(exp_of(PORT1, bus.req1_FunSel, bus.req1_A, bus.req1_B, cyc));
        grant_q.push_back(PORT1);
        grant_cnt++;
        grant_cyc = cyc;
      end
      if (prev_hold) begin
        check("resp_hold_valid", 32'(bus.resp_valid), 32'd1);
        check("resp_hold_data", 32'({bus.resp_id, bus.resp_Out, bus.resp_Flags}), 32'(prev_snap));
      end
      if (bus.resp_valid && !prev_valid && sb.size() > 0)
        check("resp_latency", 32'(cyc - sb[0].cyc), 32'd3);
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_id", 32'(bus.resp_id), 32'(e.id));
          check("resp_out", 32'(bus.resp_Out), 32'(e.out));
          check("resp_flags", 32'(bus.resp_Flags), 32'(e.flg));
        end
        last_out = bus.resp_Out;
        last_id  = bus.resp_id;
        last_flg = bus.resp_Flags;
        if (bus.resp_id) last_out1 = bus.resp_Out;
        resp_cnt++;
        resp_cyc = cyc;
      end
      prev_hold  = bus.resp_valid && !bus.resp_ready;
      prev_snap  = {bus.resp_id, bus.resp_Out, bus.resp_Flags};
      prev_valid = bus.resp_valid;
    end
  end

  task automatic check_reset_vals();
    check("rst_alu_A", 32'(bus.alu_A), 32'd0);
    check("rst_alu_B", 32'(bus.alu_B), 32'd0);
    check("rst_alu_FunSel", 32'(bus.alu_FunSel), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);
    check("rst_resp_Out", 32'(bus.resp_Out), 32'd0);
    check("rst_resp_Flags", 32'(bus.resp_Flags), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic set_req(input logic port, input logic [7:0] a, input logic [7:0] b, input logic [3:0] fs);
    if (port == PORT0) begin
      bus.req0_A = a; bus.req0_B = b; bus.req0_FunSel = fs; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_A = a; bus.req1_B = b; bus.req1_FunSel = fs; bus.req1_valid = 1'b1;
    end
  endtask

  // Waits (bounded) until grant_cnt reaches target; returns just after the handshake edge.
  task automatic wait_grants(input string tag, input int target);
    for (int i = 0; i < 200 && grant_cnt < target; i++) begin
      @(posedge clk); #1;
    end
    check(tag, 32'(grant_cnt >= target), 32'd1);
  endtask

  task automatic send(input logic port, input logic [7:0] a, input logic [7:0] b, input logic [3:0] fs);
    int g0;
    g0 = grant_cnt;
    set_req(port, a, b, fs);
    wait_grants("send_handshake", g0 + 1);
    if (port == PORT0) bus.req0_valid = 1'b0;
    else               bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sb.size() != 0 || bus.resp_valid); i++) begin
      @(posedge clk); #1;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    logic exp_g;
    bus.req0_valid = 1'b0; bus.req0_A = '0; bus.req0_B = '0; bus.req0_FunSel = '0;
    bus.req1_valid = 1'b0; bus.req1_A = '0; bus.req1_B = '0; bus.req1_FunSel = '0;
    bus.resp_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both ports valid continuously from reset.
    g0 = grant_cnt;
    set_req(PORT0, 8'h12, 8'h34, 4'b0100);
    set_req(PORT1, 8'hAA, 8'hF0, 4'b1010);
    wait_grants("rr_grants", g0 + 4);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain();
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = PORT0;
`else
      exp_g = (k % 2 == 1) ? PORT1 : PORT0;
`endif
      if (grant_q.size() > g0 + k) check("both_valid_grant", 32'(grant_q[g0 + k]), 32'(exp_g));
      else                         check("both_valid_grant_missing", 32'd0, 32'd1);
    end
`ifndef ALU_ARB_FIXED_PRIO_EN
    check("xor_out", 32'(last_out1), 32'h5A);
`endif

    // Port 0 ADD.
    send(PORT0, 8'h33, 8'h0F, 4'b0100);
    drain();
    check("add_out", 32'(last_out), 32'h42);
    check("add_id", 32'(last_id), 32'd0);
    check("add_flags", 32'(last_flg), 32'h0);

    // Response back-pressure, with a request arriving during RESP.
    bus.resp_ready = 1'b0;
    send(PORT0, 8'hF0, 8'h20, 4'b0100);
    for (int i = 0; i < 20 && !bus.resp_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
    set_req(PORT1, 8'h0F, 8'h0F, 4'b1010);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
    end
    g0 = grant_cnt;
    bus.resp_ready = 1'b1;
    wait_grants("resp_then_grant", g0 + 1);
    bus.req1_valid = 1'b0;
    check("resp_to_grant_gap", 32'(grant_cyc - resp_cyc), 32'd1);
    check("bp_out", 32'(last_out), 32'h10);
    check("bp_flags", 32'(last_flg), 32'h4);
    drain();

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Port 0 always valid starves port 1 until it drops.
    g0 = grant_cnt;
    set_req(PORT0, 8'h01, 8'h02, 4'b0100);
    set_req(PORT1, 8'h03, 8'h04, 4'b1001);
    wait_grants("fixed_grants", g0 + 3);
    bus.req0_valid = 1'b0;
    wait_grants("fixed_port1", g0 + 4);
    bus.req1_valid = 1'b0;
    drain();
    for (int k = 0; k < 4; k++) begin
      exp_g = (k == 3) ? PORT1 : PORT0;
      if (grant_q.size() > g0 + k) check("fixed_grant", 32'(grant_q[g0 + k]), 32'(exp_g));
      else                         check("fixed_grant_missing", 32'd0, 32'd1);
    end
`endif

    // Reset pulsed during CAPTURE of a port 0 operation.
    send(PORT0, 8'h81, 8'h81, 4'b0100);
    @(posedge clk); #1;
    check("in_capture_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_vals();
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    g0 = grant_cnt;
    set_req(PORT0, 8'h05, 8'h06, 4'b1000);
    set_req(PORT1, 8'h07, 8'h08, 4'b1001);
    wait_grants("post_reset_grant", g0 + 1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (grant_q.size() > g0) check("post_reset_winner", 32'(grant_q[g0]), 32'd0);
    else                     check("post_reset_winner_missing", 32'd0, 32'd1);
    drain();
    check("resp_count", 32'(resp_cnt), 32'(grant_cnt - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
